boot_loader: RTL and testbench

Boot-time program loader sitting directly upstream of `riscv_min_sopc`. It accepts a little-endian byte stream over a valid/ready handshake and writes the program into the instruction ROM's write port. It holds the CPU in reset until the whole image is written plus a programmable settle delay, then releases it. The top-level bench drives this block in place of driving the SoPC reset directly.

---
 rtl/boot_loader.sv | 163 ++++++++++++++++
 tb/tb_boot_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into words,
// writes them into instruction memory and releases the CPU reset after a settle delay.
module boot_loader #(
    parameter int ADDR_W      = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         part_q, part_d;
    logic [31:0]         len_q, len_d;
    logic [31:0]         idx_q, idx_d;
    logic [7:0]          hold_q, hold_d;
    logic                in_ready_q, in_ready_d;
    logic                rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [31:0]         rom_wdata_q, rom_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;

    logic                accept_s;
    logic [31:0]         word_s;
    logic                in_range_s;

    assign accept_s   = in_valid && in_ready_q;
    assign word_s     = {in_data, part_q};
    // Word indices past the memory depth are consumed but never written.
    assign in_range_s = ((idx_q >> ADDR_W) == 32'd0);

    // Next-state, word assembly and registered-output decode.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        part_d      = part_q;
        len_d       = len_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_LEN, S_DATA: begin
                if (accept_s) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    part_d[7:0]   = in_data;
                        2'd1:    part_d[15:8]  = in_data;
                        2'd2:    part_d[23:16] = in_data;
                        default: part_d        = 24'd0;
                    endcase
                    if (byte_cnt_q == 2'd3) begin
                        hold_d = 8'd0;
                        if (state_q == S_LEN) begin
                            len_d   = word_s;
                            state_d = (word_s == 32'd0) ? S_HOLD : S_DATA;
                        end else begin
                            idx_d = idx_q + 32'd1;
                            if (in_range_s) begin
                                rom_we_d    = 1'b1;
                                rom_addr_d  = idx_q[ADDR_W-1:0];
                                rom_wdata_d = word_s;
                            end else begin
                                overflow_d = 1'b1;
                            end
                            if (idx_q == (len_q - 32'd1)) begin
                                state_d = S_HOLD;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_LEN;
            end
        endcase

        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        cpu_rst_d  = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN;
            byte_cnt_q  <= 2'd0;
            part_q      <= 24'd0;
            len_q       <= 32'd0;
            idx_q       <= 32'd0;
            hold_q      <= 8'd0;
            in_ready_q  <= 1'b1;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= 32'd0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            part_q      <= part_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            in_ready_q  <= in_ready_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (deep memory / tiny memory) share one byte stream
// and are compared every cycle against a byte-count based model of the load protocol.
module tb_boot_loader;

    localparam int AW_A   = 10;
    localparam int AW_B   = 2;
    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      = 1'b1;
    logic       in_valid = 1'b1;
    logic [7:0] in_data  = 8'hAA;

    logic            rdy_a, we_a, cr_a, dn_a, ov_a;
    logic [AW_A-1:0] addr_a;
    logic [31:0]     wd_a;
    logic            rdy_b, we_b, cr_b, dn_b, ov_b;
    logic [AW_B-1:0] addr_b;
    logic [31:0]     wd_b;

    boot_loader #(.ADDR_W(AW_A), .HOLD_CYCLES(HOLD_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .rom_we(we_a), .rom_addr(addr_a), .rom_wdata(wd_a),
        .cpu_rst(cr_a), .done(dn_a), .overflow(ov_a)
    );

    boot_loader #(.ADDR_W(AW_B), .HOLD_CYCLES(HOLD_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .rom_we(we_b), .rom_addr(addr_b), .rom_wdata(wd_b),
        .cpu_rst(cr_b), .done(dn_b), .overflow(ov_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: everything is derived from the list of accepted bytes.
    logic [7:0]  m_bytes[$];
    longint      m_total      = -1;
    longint      m_edge       = 0;
    longint      m_final_edge = 0;
    bit          m_final      = 1'b0;
    bit          m_we[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd[2];
    bit          m_ov[2];

    logic [31:0] words[$];
    logic [7:0]  img[$];

    function automatic longint depth_of(input int i);
        return (i == 0) ? (longint'(1) << AW_A) : (longint'(1) << AW_B);
    endfunction

    function automatic longint hold_of(input int i);
        return (i == 0) ? longint'(HOLD_A) : longint'(HOLD_B);
    endfunction

    function automatic bit m_ready();
        return (m_total < 0) || (longint'(m_bytes.size()) < m_total);
    endfunction

    function automatic bit m_done(input int i);
        return m_final && ((m_edge - m_final_edge) >= hold_of(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int          n;
        longint      widx;
        logic [31:0] word;
        m_edge++;
        if (rst) begin
            m_bytes.delete();
            m_total = -1;
            m_final = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_we[i] = 1'b0; m_addr[i] = 32'd0; m_wd[i] = 32'd0; m_ov[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) m_we[i] = 1'b0;
            if (in_valid && m_ready()) begin
                m_bytes.push_back(in_data);
                n = m_bytes.size();
                if ((n % 4) == 0) begin
                    word = {m_bytes[n-1], m_bytes[n-2], m_bytes[n-3], m_bytes[n-4]};
                    if (n == 4) begin
                        m_total = 64'd4 + 64'd4 * longint'(word);
                    end else begin
                        widx = longint'(n / 4 - 2);
                        for (int i = 0; i < 2; i++) begin
                            if (widx < depth_of(i)) begin
                                m_we[i] = 1'b1; m_addr[i] = 32'(widx); m_wd[i] = word;
                            end else begin
                                m_ov[i] = 1'b1;
                            end
                        end
                    end
                    if (longint'(n) == m_total) begin
                        m_final = 1'b1;
                        m_final_edge = m_edge;
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("a.in_ready", 32'(rdy_a),  32'(m_ready()));
        chk("a.rom_we",   32'(we_a),   32'(m_we[0]));
        chk("a.rom_addr", 32'(addr_a), m_addr[0]);
        chk("a.rom_wdata", wd_a,       m_wd[0]);
        chk("a.cpu_rst",  32'(cr_a),   32'(!m_done(0)));
        chk("a.done",     32'(dn_a),   32'(m_done(0)));
        chk("a.overflow", 32'(ov_a),   32'(m_ov[0]));
        chk("b.in_ready", 32'(rdy_b),  32'(m_ready()));
        chk("b.rom_we",   32'(we_b),   32'(m_we[1]));
        chk("b.rom_addr", 32'(addr_b), m_addr[1]);
        chk("b.rom_wdata", wd_b,       m_wd[1]);
        chk("b.cpu_rst",  32'(cr_b),   32'(!m_done(1)));
        chk("b.done",     32'(dn_b),   32'(m_done(1)));
        chk("b.overflow", 32'(ov_b),   32'(m_ov[1]));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        in_valid = 1'b1;
        for (int j = 0; j < cycles; j++) begin
            in_data = 8'($urandom);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic build();
        logic [31:0] len;
        len = 32'(words.size());
        img.delete();
        for (int b = 0; b < 4; b++) img.push_back(len[8*b +: 8]);
        foreach (words[w]) begin
            logic [31:0] cw;
            cw = words[w];
            for (int b = 0; b < 4; b++) img.push_back(cw[8*b +: 8]);
        end
    endtask

    task automatic play(input int nbytes, input int max_gap, input bit alt);
        for (int k = 0; k < nbytes && k < img.size(); k++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (alt) g = g + 1;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = img[k];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic tail(input int cycles);
        for (int j = 0; j < cycles; j++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int w = 0; w < n; w++) words.push_back($urandom);
    endtask

    initial begin
        // Reset held with valid asserted: nothing may be consumed.
        do_reset(3);

        // Basic two-word image at one byte per cycle, then extra bytes offered.
        words = '{32'h00100513, 32'h00200593};
        build();
        play(img.size(), 0, 1'b0);
        in_valid = 1'b1;
        tail(8);

        // Same image from a throttled source.
        do_reset(1);
        build();
        play(img.size(), 3, 1'b1);
        tail(8);

        // Zero-length image.
        do_reset(1);
        words.delete();
        build();
        play(img.size(), 0, 1'b0);
        tail(8);

        // Five words: overflows the 4-deep instance only.
        do_reset(1);
        rand_words(5);
        build();
        play(img.size(), 1, 1'b0);
        tail(8);

        // Reset after two bytes of word 1, then a fresh one-word image.
        do_reset(1);
        words = '{32'h11223344, 32'h55667788};
        build();
        play(10, 0, 1'b0);
        do_reset(1);
        words = '{32'hDEADBEEF};
        build();
        play(img.size(), 0, 1'b0);
        tail(8);

        // Randomised images, some cut short by reset.
        for (int t = 0; t < 20; t++) begin
            int cut;
            do_reset(int'($urandom_range(2, 1)));
            rand_words(int'($urandom_range(7, 0)));
            build();
            cut = (($urandom % 4) == 0) ? int'($urandom_range(img.size(), 0)) : img.size();
            play(cut, int'($urandom_range(2, 0)), 1'b0);
            tail(6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
